// File: rtl/n106_wave_ram_port.sv
// rtl/n106_wave_ram_port.sv - Namco 163/106 wavetable RAM with CPU address/data ports and mixer fetch port
module n106_wave_ram_port #(
    parameter int          ADDR_W    = 7,
    parameter logic [4:0]  DATA_PAGE = 5'b01001,
    parameter logic [4:0]  ADDR_PAGE = 5'b11111
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              ce,
    input  logic [15:0]       prg_ain,
    input  logic              prg_read,
    input  logic              prg_write,
    input  logic [7:0]        prg_din,
    output logic [7:0]        prg_dout,
    output logic              prg_oe,
    input  logic              mix_req,
    input  logic [ADDR_W-1:0] mix_addr,
    output logic [7:0]        mix_data,
    output logic              mix_ack
);
    typedef enum logic [1:0] {S_IDLE, S_CPU_RD, S_MIX_RD} state_t;

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [7:0]        mem_q [0:DEPTH-1];
    logic [7:0]        rdata_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              autoinc_q;
    logic [7:0]        prg_dout_q;
    logic              prg_oe_q;
    logic [7:0]        mix_data_q;
    logic              mix_ack_q;

    logic              rst;
    logic              ap_hit;
    logic              dp_hit;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
    logic              ptr_inc;
    logic              cpu_rd_start;
    logic              mix_start;
    logic              unused_ain;

    assign rst        = reset | ~enable;
    assign ap_hit     = ce & prg_write & (prg_ain[15:11] == ADDR_PAGE);
    assign dp_hit     = ce & (prg_read | prg_write) & (prg_ain[15:11] == DATA_PAGE);
    assign unused_ain = ^prg_ain[10:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_rd_start) begin
                    state_d = S_CPU_RD;
                end else if (mix_start) begin
                    state_d = S_MIX_RD;
                end
            end
            S_CPU_RD: state_d = S_IDLE;
            S_MIX_RD: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // CPU wins the RAM port; the mixer is also held off during its own ack clk
    // so a still-asserted request with the old address is not fetched twice.
    always_comb begin
        ram_we       = 1'b0;
        ram_re       = 1'b0;
        ram_raddr    = ptr_q;
        ptr_inc      = 1'b0;
        cpu_rd_start = 1'b0;
        mix_start    = 1'b0;
        if (state_q == S_IDLE && !rst) begin
            if (dp_hit) begin
                ptr_inc = autoinc_q;
                if (prg_write) begin
                    ram_we = 1'b1;
                end else begin
                    ram_re       = 1'b1;
                    cpu_rd_start = 1'b1;
                end
            end else if (mix_req && !mix_ack_q) begin
                ram_re    = 1'b1;
                ram_raddr = mix_addr;
                mix_start = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[ptr_q] <= prg_din;
        end
        if (ram_re) begin
            rdata_q <= mem_q[ram_raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            autoinc_q  <= 1'b0;
            prg_dout_q <= 8'h00;
            prg_oe_q   <= 1'b0;
            mix_data_q <= 8'h00;
            mix_ack_q  <= 1'b0;
        end else begin
            if (ap_hit) begin
                ptr_q     <= prg_din[ADDR_W-1:0];
                autoinc_q <= prg_din[7];
            end else if (ptr_inc) begin
                ptr_q <= ptr_q + PTR_ONE;
            end
            if (ce) begin
                prg_oe_q <= cpu_rd_start;
            end
            if (state_q == S_CPU_RD) begin
                prg_dout_q <= rdata_q;
            end
            if (state_q == S_MIX_RD) begin
                mix_data_q <= rdata_q;
            end
            mix_ack_q <= (state_q == S_MIX_RD);
        end
    end

    assign prg_dout = prg_dout_q;
    assign prg_oe   = prg_oe_q;
    assign mix_data = mix_data_q;
    assign mix_ack  = mix_ack_q;
endmodule

// File: tb/tb_n106_wave_ram_port.sv
// tb/tb_n106_wave_ram_port.sv - self-checking bench for n106_wave_ram_port against a byte-array model
module tb_n106_wave_ram_port;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        ce = 1'b0;
    logic [15:0] prg_ain = 16'h0000;
    logic        prg_read = 1'b0;
    logic        prg_write = 1'b0;
    logic [7:0]  prg_din = 8'h00;
    logic [7:0]  prg_dout;
    logic        prg_oe;
    logic        mix_req = 1'b0;
    logic [6:0]  mix_addr = 7'h00;
    logic [7:0]  mix_data;
    logic        mix_ack;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [0:127];
    int         m_ptr = 0;
    logic       m_ai = 1'b0;

    n106_wave_ram_port dut (
        .clk(clk), .reset(reset), .enable(enable), .ce(ce),
        .prg_ain(prg_ain), .prg_read(prg_read), .prg_write(prg_write), .prg_din(prg_din),
        .prg_dout(prg_dout), .prg_oe(prg_oe),
        .mix_req(mix_req), .mix_addr(mix_addr), .mix_data(mix_data), .mix_ack(mix_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU bus cycle: ce strobe for one clk, then two quiet clks.
    task automatic cpu_op(input logic [15:0] a, input logic wr, input logic [7:0] d);
        prg_ain = a; prg_write = wr; prg_read = !wr; prg_din = d; ce = 1'b1;
        tick();
        ce = 1'b0; prg_read = 1'b0; prg_write = 1'b0;
        tick();
        tick();
    endtask

    task automatic ap_write(input logic [7:0] d);
        cpu_op(16'hF800 | 16'($urandom_range(0, 16'h07FF)), 1'b1, d);
        m_ptr = int'(d[6:0]);
        m_ai  = d[7];
    endtask

    task automatic dp_write(input logic [7:0] d);
        cpu_op(16'h4800 | 16'($urandom_range(0, 16'h07FF)), 1'b1, d);
        m_mem[m_ptr] = d;
        if (m_ai) m_ptr = (m_ptr + 1) % 128;
    endtask

    task automatic dp_read(output logic [7:0] got, output logic oe, output logic [7:0] exp);
        exp = m_mem[m_ptr];
        if (m_ai) m_ptr = (m_ptr + 1) % 128;
        cpu_op(16'h4800 | 16'($urandom_range(0, 16'h07FF)), 1'b0, 8'h00);
        got = prg_dout;
        oe  = prg_oe;
    endtask

    task automatic mix_fetch(input logic [6:0] a, output logic [7:0] got, output logic acked, output int lat);
        mix_req = 1'b1; mix_addr = a; lat = 0;
        do begin
            tick();
            lat++;
        end while (!mix_ack && lat < 8);
        acked = mix_ack;
        got = mix_data;
        mix_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (prg_dout !== 8'h00 || prg_oe !== 1'b0 || mix_data !== 8'h00 || mix_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: dout=%h oe=%b mdata=%h ack=%b, required 00 0 00 0",
                     prg_dout, prg_oe, mix_data, mix_ack);
        end
        reset = 1'b0;
        tick();
        m_ptr = 0; m_ai = 1'b0;
    endtask

    task automatic test_fill();
        ap_write(8'h80);
        for (int i = 0; i < 128; i++) dp_write(8'($urandom));
    endtask

    task automatic test_autoinc_write_read();
        logic [7:0] got, exp; logic oe;
        ap_write(8'h80);
        dp_write(8'h11); dp_write(8'h22); dp_write(8'h33); dp_write(8'h44);
        ap_write(8'h82);
        dp_read(got, oe, exp);
        checks++;
        if (got !== 8'h33 || exp !== 8'h33 || oe !== 1'b1) begin
            errors++;
            $display("FAIL read_33: dout=%h oe=%b, required 33 1", got, oe);
        end
        dp_read(got, oe, exp);
        checks++;
        if (got !== 8'h44 || oe !== 1'b1) begin
            errors++;
            $display("FAIL read_44: dout=%h oe=%b, required 44 1", got, oe);
        end
        dp_read(got, oe, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL read_ptr4: dout=%h, required %h", got, exp);
        end
        ap_write(8'h00);
        checks++;
        if (prg_oe !== 1'b0) begin
            errors++;
            $display("FAIL oe_clear: oe=%b, required 0", prg_oe);
        end
        checks++;
        if (prg_dout !== exp) begin
            errors++;
            $display("FAIL dout_hold: dout=%h, required %h", prg_dout, exp);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] got, exp; logic oe;
        ap_write(8'hFF);
        dp_write(8'hAA); dp_write(8'hBB);
        ap_write(8'hFF);
        dp_read(got, oe, exp);
        checks++;
        if (got !== 8'hAA) begin
            errors++;
            $display("FAIL wrap_7f: dout=%h, required aa", got);
        end
        dp_read(got, oe, exp);
        checks++;
        if (got !== 8'hBB) begin
            errors++;
            $display("FAIL wrap_00: dout=%h, required bb", got);
        end
    endtask

    task automatic test_arbitration();
        int lat;
        ap_write(8'h02);
        prg_ain = 16'h4800; prg_write = 1'b1; prg_din = 8'h55; ce = 1'b1;
        mix_req = 1'b1; mix_addr = 7'h02; lat = 0;
        m_mem[2] = 8'h55;
        do begin
            tick();
            ce = 1'b0; prg_write = 1'b0;
            lat++;
        end while (!mix_ack && lat < 8);
        checks++;
        if (mix_ack !== 1'b1 || lat > 4 || mix_data !== 8'h55) begin
            errors++;
            $display("FAIL arb_fetch: ack=%b lat=%0d data=%h, required 1 <=4 55", mix_ack, lat, mix_data);
        end
        mix_req = 1'b0;
        tick();
        checks++;
        if (mix_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse: ack=%b, required 0", mix_ack);
        end
        tick();
    endtask

    task automatic test_no_autoinc();
        logic [7:0] got, exp; logic oe;
        ap_write(8'h05);
        for (int i = 0; i < 3; i++) begin
            dp_read(got, oe, exp);
            checks++;
            if (got !== m_mem[5] || oe !== 1'b1) begin
                errors++;
                $display("FAIL fixed_ptr_read%0d: dout=%h oe=%b, required %h 1", i, got, oe, m_mem[5]);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0] got, exp; logic oe; int acks;
        mix_req = 1'b1; mix_addr = 7'h10;
        tick();
        reset = 1'b1;
        tick();
        acks = 0;
        checks++;
        if (mix_ack !== 1'b0 || prg_oe !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ack=%b oe=%b, required 0 0", mix_ack, prg_oe);
        end
        mix_req = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mix_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL dropped_ack: acks=%0d, required 0", acks);
        end
        m_ptr = 0; m_ai = 1'b0;
        dp_read(got, oe, exp);
        checks++;
        if (got !== 8'hBB) begin
            errors++;
            $display("FAIL ram_kept: dout=%h, required bb", got);
        end
    endtask

    task automatic test_enable_low();
        logic [7:0] got, exp; logic oe;
        ap_write(8'h9A);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        m_ptr = 0; m_ai = 1'b0;
        dp_read(got, oe, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL enable_low_ptr: dout=%h, required %h", got, exp);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, exp; logic oe, acked; int lat; logic [6:0] a;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: ap_write(8'($urandom));
                1: dp_write(8'($urandom));
                2: begin
                    dp_read(got, oe, exp);
                    checks++;
                    if (got !== exp || oe !== 1'b1) begin
                        errors++;
                        $display("FAIL rand_read%0d: dout=%h oe=%b, required %h 1", n, got, oe, exp);
                    end
                end
                default: begin
                    a = 7'($urandom);
                    mix_fetch(a, got, acked, lat);
                    checks++;
                    if (!acked || lat > 4 || got !== m_mem[a]) begin
                        errors++;
                        $display("FAIL rand_fetch%0d: ack=%b lat=%0d data=%h, required 1 <=4 %h",
                                 n, acked, lat, got, m_mem[a]);
                    end
                end
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_autoinc_write_read();
        test_wrap();
        test_arbitration();
        test_no_autoinc();
        test_reset_mid_fetch();
        test_enable_low();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
